breadboard_sweeper: RTL and testbench
=====================================

BREADBOARD_SWEEPER -- requirements
Module: breadboard_sweeper

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, meaning clock cycles to hold each vector before sampling (legal 1..255).
REQ-002 SHALL have parameter LAST_INDEX, default 15, meaning final vector index of a sweep (legal 0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a sweep.
REQ-006 SHALL have port w, x, y, z  output  1 each  stimulus bits to the breadboard logic stage, w = index bit 3, z = index bit 0.
REQ-007 SHALL have port r  input  10  breadboard results r0..r9, where r[0] = r0.
REQ-008 SHALL have port res_valid  output  1  captured result available.
REQ-009 SHALL have port res_ready  input  1  consumer accepts the result when res_ready and res_valid are both high.
REQ-010 SHALL have port res_index  output  4  vector index of the captured result.
REQ-011 SHALL have port res_data  output  10  captured r.
REQ-012 SHALL have port busy  output  1  high from sweep start until DONE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the final result is accepted.
REQ-014 SHALL have port checksum  output  10  running XOR of accepted results (see Configuration).

Function
REQ-015 SHALL implement states IDLE, DRIVE, CAPTURE, PRESENT and DONE.
REQ-016 IDLE: start=1 SHALL clear index to 0 and the settle counter to 0, then go to DRIVE; start=0 SHALL stay in IDLE.
REQ-017 DRIVE: {w,x,y,z} SHALL equal index; the counter SHALL increment each cycle; when counter = SETTLE_CYCLES-1 the block SHALL go to CAPTURE.
REQ-018 CAPTURE: res_data<=r and res_index<=index SHALL be registered in this single cycle; the block SHALL then go to PRESENT.
REQ-019 PRESENT: res_valid SHALL be 1; res_data and res_index SHALL be held stable until handshake; {w,x,y,z} SHALL remain index.
REQ-020 PRESENT with handshake and index<LAST_INDEX SHALL increment index, clear the counter and go to DRIVE.
REQ-021 PRESENT with handshake and index=LAST_INDEX SHALL go to DONE; index SHALL NOT wrap.
REQ-022 DONE SHALL last exactly one cycle with done=1 and busy=0, then go to IDLE.
REQ-023 Latency SHALL be 1 cycle from start to DRIVE entry, and SETTLE_CYCLES+1 cycles from DRIVE entry to res_valid=1.
REQ-024 start asserted in any state other than IDLE SHALL be ignored.
REQ-025 res_ready while res_valid=0 SHALL have no effect.
REQ-026 busy SHALL be 1 in DRIVE, CAPTURE and PRESENT, and 0 otherwise.
REQ-027 {w,x,y,z} SHALL be 0000 in IDLE and DONE.

Reset
REQ-028 rst=1 SHALL asynchronously force state IDLE, with index, counter, w, x, y, z, res_valid, res_index, res_data, busy, done and checksum all 0.
REQ-029 rst asserted mid-sweep SHALL abandon the sweep; after release, no result SHALL appear until a new start.

Configuration
REQ-030 With macro SWEEP_CHECKSUM_EN defined, checksum SHALL be updated to checksum XOR res_data on every handshake, and SHALL be cleared to 0 on each accepted start.
REQ-031 With SWEEP_CHECKSUM_EN undefined, checksum SHALL be tied to 0 and no checksum register SHALL exist.

Verification
REQ-032 Scenario: reset, then start with res_ready=1 held -> 16 results with res_index 0..15 in order, each res_data matching the breadboard reference for that index, then a single done pulse.
REQ-033 Scenario: res_ready=0 for 7 cycles during PRESENT at index 5 -> res_valid, res_index=5 and res_data hold unchanged, and wxyz=0101 is held.
REQ-034 Scenario: SETTLE_CYCLES=1 and LAST_INDEX=0 -> res_valid rises 3 cycles after start, and done pulses on the cycle after the handshake.
REQ-035 Scenario: rst pulsed while in DRIVE at index 9 -> all outputs are 0 immediately, and no res_valid appears without a new start.
REQ-036 Scenario: start pulsed repeatedly during the sweep -> the sequence is unaltered and exactly 16 results are produced.
REQ-037 Scenario, with SWEEP_CHECKSUM_EN: r tied to 10'h3FF -> checksum is 0 after 16 accepted results.

Source files
------------

// File: rtl/breadboard_sweeper.sv
// breadboard_sweeper: steps a 4-bit stimulus index through 0..LAST_INDEX on
// {w,x,y,z}, lets the breadboard settle for SETTLE_CYCLES clocks, captures the
// 10-bit result r and offers it to a consumer on a valid/ready handshake.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle sweep request (honoured only in IDLE)
//   w, x, y, z          stimulus bits, w = index[3], z = index[0]
//   r                   breadboard results r0..r9 (r[0] = r0)
//   res_valid/res_ready result handshake
//   res_index, res_data index and captured r of the presented result
//   busy                high in DRIVE, CAPTURE and PRESENT
//   done                one-cycle pulse after the final result is accepted
//   checksum            XOR of accepted results since the last start
//
// Optional feature: define SWEEP_CHECKSUM_EN to build the checksum register;
// otherwise checksum is tied to zero.
module breadboard_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LAST_INDEX    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       w,
    output logic       x,
    output logic       y,
    output logic       z,
    input  logic [9:0] r,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_index,
    output logic [9:0] res_data,
    output logic       busy,
    output logic       done,
    output logic [9:0] checksum
);

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned RES_W = 10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LAST_INDEX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_CAPTURE,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t             state, state_d;
    logic [IDX_W-1:0]   index, index_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [IDX_W-1:0]   wxyz_d;
    logic [IDX_W-1:0]   res_index_d;
    logic [RES_W-1:0]   res_data_d;
    logic               res_valid_d;
    logic               busy_d;
    logic               done_d;

    // Next-state logic; registered outputs are decoded from the next state so
    // they line up with the state they describe.
    always_comb begin
        state_d     = state;
        index_d     = index;
        cnt_d       = cnt;
        res_index_d = res_index;
        res_data_d  = res_data;

        case (state)
            S_IDLE: begin
                if (start) begin
                    index_d = '0;
                    cnt_d   = '0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_LAST) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                res_data_d  = r;
                res_index_d = index;
                state_d     = S_PRESENT;
            end
            S_PRESENT: begin
                if (res_ready) begin
                    if (index == IDX_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index + IDX_W'(1);
                        cnt_d   = '0;
                        state_d = S_DRIVE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d == S_DRIVE) || (state_d == S_CAPTURE) ||
                      (state_d == S_PRESENT);
        res_valid_d = (state_d == S_PRESENT);
        done_d      = (state_d == S_DONE);
        wxyz_d      = busy_d ? index_d : '0;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            index     <= '0;
            cnt       <= '0;
            {w, x, y, z} <= '0;
            res_valid <= 1'b0;
            res_index <= '0;
            res_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            index     <= index_d;
            cnt       <= cnt_d;
            {w, x, y, z} <= wxyz_d;
            res_valid <= res_valid_d;
            res_index <= res_index_d;
            res_data  <= res_data_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

`ifdef SWEEP_CHECKSUM_EN
    logic [RES_W-1:0] checksum_q;

    // Cleared on an accepted start, folds in each result as it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else if ((state == S_IDLE) && start) begin
            checksum_q <= '0;
        end else if ((state == S_PRESENT) && res_ready) begin
            checksum_q <= checksum_q ^ res_data;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_breadboard_sweeper.sv
// Directed testbench for breadboard_sweeper: a default-parameter instance and
// a minimal instance (SETTLE_CYCLES=1, LAST_INDEX=0), both fed by a small
// combinational breadboard model.
module tb_breadboard_sweeper;

    logic       clk;
    logic       rst;
    logic       start;
    logic       ready;
    logic       force_ones;
    logic       w, x, y, z;
    logic [9:0] r;
    logic       res_valid;
    logic [3:0] res_index;
    logic [9:0] res_data;
    logic       busy;
    logic       done;
    logic [9:0] checksum;

    logic       start_s;
    logic       ready_s;
    logic       w_s, x_s, y_s, z_s;
    logic [9:0] r_s;
    logic       res_valid_s;
    logic [3:0] res_index_s;
    logic [9:0] res_data_s;
    logic       busy_s;
    logic       done_s;
    logic [9:0] checksum_s;

    int vectors;
    int errors;

`ifdef SWEEP_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    // Breadboard reference: arbitrary but index-unique logic with odd overall
    // parity so a full sweep leaves a nonzero checksum.
    function automatic logic [9:0] bb(input logic [3:0] v);
        return {v ^ 4'hA, &v, v[2] | v[1], ~v};
    endfunction

    assign r   = force_ones ? 10'h3FF : bb({w, x, y, z});
    assign r_s = bb({w_s, x_s, y_s, z_s});

    breadboard_sweeper dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .w         (w),
        .x         (x),
        .y         (y),
        .z         (z),
        .r         (r),
        .res_valid (res_valid),
        .res_ready (ready),
        .res_index (res_index),
        .res_data  (res_data),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum)
    );

    breadboard_sweeper #(.SETTLE_CYCLES(1), .LAST_INDEX(0)) dut_s (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .w         (w_s),
        .x         (x_s),
        .y         (y_s),
        .z         (z_s),
        .r         (r_s),
        .res_valid (res_valid_s),
        .res_ready (ready_s),
        .res_index (res_index_s),
        .res_data  (res_data_s),
        .busy      (busy_s),
        .done      (done_s),
        .checksum  (checksum_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if ({w, x, y, z} !== 4'h0) begin errors++; $display("FAIL reset_wxyz: got %h expected 0", {w, x, y, z}); end
        vectors++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
        vectors++; if (res_index !== 4'h0) begin errors++; $display("FAIL reset_res_index: got %h expected 0", res_index); end
        vectors++; if (res_data !== 10'h0) begin errors++; $display("FAIL reset_res_data: got %h expected 0", res_data); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (checksum !== 10'h0) begin errors++; $display("FAIL reset_checksum: got %h expected 0", checksum); end
        vectors++; if ({res_valid_s, busy_s, done_s} !== 3'b000) begin errors++; $display("FAIL reset_small: got %b expected 000", {res_valid_s, busy_s, done_s}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // res_ready with nothing to present, and no start, must leave IDLE alone.
    task automatic test_idle_ready();
        int seen;
        seen = 0;
        ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (res_valid !== 1'b0 || busy !== 1'b0 || {w, x, y, z} !== 4'h0) seen++;
        end
        vectors++; if (seen !== 0) begin errors++; $display("FAIL idle_ready: got %0d active cycles expected 0", seen); end
    endtask

    task automatic test_full_sweep();
        int n;
        int done_seen;
        logic [3:0] ei;
        logic [9:0] ck;
        n = 0; done_seen = 0; ck = '0;
        ready = 1'b1;
        pulse_start();
        vectors++; if ({busy, w, x, y, z} !== 5'b10000) begin errors++; $display("FAIL sweep_drive_entry: got %b expected 10000", {busy, w, x, y, z}); end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                ei = 4'(n);
                vectors++; if (res_index !== ei) begin errors++; $display("FAIL sweep_index: got %h expected %h", res_index, ei); end
                vectors++; if (res_data !== bb(ei)) begin errors++; $display("FAIL sweep_data: got %h expected %h", res_data, bb(ei)); end
                vectors++; if ({w, x, y, z} !== ei) begin errors++; $display("FAIL sweep_wxyz: got %h expected %h", {w, x, y, z}, ei); end
                ck = ck ^ bb(ei);
                n++;
            end
            if (done === 1'b1) begin
                done_seen = 1;
                vectors++; if ({busy, res_valid, w, x, y, z} !== 6'b0) begin errors++; $display("FAIL sweep_done_outputs: got %b expected 000000", {busy, res_valid, w, x, y, z}); end
                break;
            end
        end
        vectors++; if (done_seen !== 1) begin errors++; $display("FAIL sweep_done_timeout: got %0d expected 1", done_seen); end
        vectors++; if (n !== 16) begin errors++; $display("FAIL sweep_count: got %0d expected 16", n); end
        vectors++; if (checksum !== (CK_EN ? ck : 10'h0)) begin errors++; $display("FAIL sweep_checksum: got %h expected %h", checksum, CK_EN ? ck : 10'h0); end
        @(negedge clk);
        vectors++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL sweep_done_width: got %b expected 00", {done, busy}); end
    endtask

    task automatic test_stall();
        int n;
        int done_seen;
        int bad;
        n = 0; done_seen = 0; bad = 0;
        ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                if (n == 5) begin
                    ready = 1'b0;
                    repeat (7) begin
                        @(negedge clk);
                        vectors++;
                        if ({res_valid, res_index, res_data, w, x, y, z} !== {1'b1, 4'h5, bb(4'h5), 4'h5}) begin
                            errors++;
                            $display("FAIL stall_hold: got %b/%h/%h/%h expected 1/5/%h/5", res_valid, res_index, res_data, {w, x, y, z}, bb(4'h5));
                        end
                    end
                    ready = 1'b1;
                end
                if (res_index !== 4'(n)) bad++;
                n++;
            end
            if (done === 1'b1) begin done_seen = 1; break; end
        end
        vectors++; if (bad !== 0) begin errors++; $display("FAIL stall_order: got %0d out-of-order results expected 0", bad); end
        vectors++; if (done_seen !== 1 || n !== 16) begin errors++; $display("FAIL stall_count: got done=%0d n=%0d expected done=1 n=16", done_seen, n); end
        @(negedge clk);
    endtask

    task automatic test_start_spam();
        int n;
        int done_seen;
        int bad;
        int extra;
        n = 0; done_seen = 0; bad = 0; extra = 0;
        ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 400; c++) begin
            start = c[0];
            @(negedge clk);
            if (res_valid === 1'b1) begin
                if (res_index !== 4'(n) || res_data !== bb(4'(n))) bad++;
                n++;
            end
            if (done === 1'b1) begin done_seen = 1; start = 1'b0; break; end
        end
        start = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (res_valid === 1'b1 || busy === 1'b1) extra++;
        end
        vectors++; if (bad !== 0) begin errors++; $display("FAIL spam_order: got %0d bad results expected 0", bad); end
        vectors++; if (done_seen !== 1 || n !== 16) begin errors++; $display("FAIL spam_count: got done=%0d n=%0d expected done=1 n=16", done_seen, n); end
        vectors++; if (extra !== 0) begin errors++; $display("FAIL spam_restart: got %0d active cycles expected 0", extra); end
    endtask

    task automatic test_ones();
        int n;
        int done_seen;
        int bad;
        n = 0; done_seen = 0; bad = 0;
        force_ones = 1'b1;
        ready = 1'b1;
        pulse_start();
        vectors++; if (checksum !== 10'h0) begin errors++; $display("FAIL ones_start_clear: got %h expected 0", checksum); end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (res_valid === 1'b1) begin
                if (res_data !== 10'h3FF) bad++;
                if (n == 1) begin
                    vectors++; if (checksum !== (CK_EN ? 10'h3FF : 10'h0)) begin errors++; $display("FAIL ones_partial: got %h expected %h", checksum, CK_EN ? 10'h3FF : 10'h0); end
                end
                n++;
            end
            if (done === 1'b1) begin done_seen = 1; break; end
        end
        vectors++; if (bad !== 0 || done_seen !== 1 || n !== 16) begin errors++; $display("FAIL ones_sweep: got bad=%0d done=%0d n=%0d expected 0/1/16", bad, done_seen, n); end
        vectors++; if (checksum !== 10'h0) begin errors++; $display("FAIL ones_checksum: got %h expected 0", checksum); end
        force_ones = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_small();
        int lat;
        lat = 0;
        ready_s = 1'b0;
        @(negedge clk);
        start_s = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            start_s = 1'b0;
            lat++;
            if (res_valid_s === 1'b1) break;
        end
        vectors++; if (lat !== 3) begin errors++; $display("FAIL small_latency: got %0d expected 3", lat); end
        vectors++; if ({res_index_s, res_data_s} !== {4'h0, bb(4'h0)}) begin errors++; $display("FAIL small_result: got %h/%h expected 0/%h", res_index_s, res_data_s, bb(4'h0)); end
        ready_s = 1'b1;
        @(negedge clk);
        ready_s = 1'b0;
        vectors++; if ({done_s, busy_s, res_valid_s} !== 3'b100) begin errors++; $display("FAIL small_done: got %b expected 100", {done_s, busy_s, res_valid_s}); end
        @(negedge clk);
        vectors++; if ({done_s, busy_s, res_valid_s} !== 3'b000) begin errors++; $display("FAIL small_idle: got %b expected 000", {done_s, busy_s, res_valid_s}); end
    endtask

    task automatic test_reset_mid();
        int found;
        int seen;
        found = 0; seen = 0;
        ready = 1'b1;
        pulse_start();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if ({w, x, y, z} === 4'h9 && busy === 1'b1 && res_valid === 1'b0) begin found = 1; break; end
        end
        vectors++; if (found !== 1) begin errors++; $display("FAIL midrst_reach: got %0d expected 1", found); end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({w, x, y, z, res_valid, res_index, res_data, busy, done, checksum} !== 31'h0) begin
            errors++;
            $display("FAIL midrst_outputs: got %h expected 0", {w, x, y, z, res_valid, res_index, res_data, busy, done, checksum});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (res_valid === 1'b1 || busy === 1'b1) seen++;
        end
        vectors++; if (seen !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", seen); end
    endtask

    initial begin
        vectors    = 0;
        errors     = 0;
        rst        = 1'b1;
        start      = 1'b0;
        ready      = 1'b0;
        force_ones = 1'b0;
        start_s    = 1'b0;
        ready_s    = 1'b0;

        test_reset();
        test_idle_ready();
        test_full_sweep();
        test_stall();
        test_start_spam();
        test_ones();
        test_small();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
